// File: rtl/kwta_inhibition.sv
// -----------------------------------------------------------------------------
// kwta_inhibition
//
// k-winner-take-all lateral inhibition for a temporal-coded column. During one
// gamma period of T_PERIOD cycles it passes through only the first K_WINNERS
// neuron spikes (earliest time first, then by tie-break priority). All later
// spikes in the period are inhibited. Each neuron can win at most once.
//
// Optional feature macro: KWTA_TIE_ROTATE_EN
//   defined   : simultaneous spikes are ordered starting from a rotating
//               priority pointer. The pointer moves to (first_winner+1) mod N
//               after every period that had at least one winner.
//   undefined : fixed lowest-index-first priority.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   gamma_start   one-cycle pulse that starts a new period (aborts one in RUN)
//   spike_in      raw spike volley, one bit per neuron
//   spike_out     accepted spikes, registered (one cycle after spike_in)
//   time_val      current period time, T_PERIOD outside RUN
//   busy          high while collecting spikes (RUN)
//   period_done   one-cycle pulse in the DONE cycle
//   win_mask      winners of the last completed period
//   win_count     number of winners of the last completed period
//   first_winner  index of the earliest winner, all-ones if none
//   first_time    time of the earliest winner, T_PERIOD if none
// -----------------------------------------------------------------------------
module kwta_inhibition #(
  parameter int N_NEURONS = 16,
  parameter int T_PERIOD  = 8,
  parameter int K_WINNERS = 1,
  localparam int TW = $clog2(T_PERIOD) + 1,
  localparam int IW = $clog2(N_NEURONS) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gamma_start,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic [N_NEURONS-1:0] spike_out,
  output logic [TW-1:0]        time_val,
  output logic                 busy,
  output logic                 period_done,
  output logic [N_NEURONS-1:0] win_mask,
  output logic [IW-1:0]        win_count,
  output logic [IW-1:0]        first_winner,
  output logic [TW-1:0]        first_time
);

  localparam int IX = $clog2(N_NEURONS);
  localparam logic [IW-1:0] K_L    = IW'(K_WINNERS);
  localparam logic [IW-1:0] N_L    = IW'(N_NEURONS);
  localparam logic [TW-1:0] T_L    = TW'(T_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(T_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        time_q, time_d;
  logic [N_NEURONS-1:0] seen_q, seen_d;
  logic [IW-1:0]        count_q, count_d;
  logic [N_NEURONS-1:0] work_mask_q, work_mask_d;
  logic [IW-1:0]        work_fw_q, work_fw_d;
  logic [TW-1:0]        work_ft_q, work_ft_d;
  logic [N_NEURONS-1:0] spike_out_q, spike_out_d;
  logic [N_NEURONS-1:0] win_mask_q, win_mask_d;
  logic [IW-1:0]        win_count_q, win_count_d;
  logic [IW-1:0]        first_winner_q, first_winner_d;
  logic [TW-1:0]        first_time_q, first_time_d;
  logic [IW-1:0]        rot_base;

`ifdef KWTA_TIE_ROTATE_EN
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        ptr_next;
  assign rot_base = ptr_q;
`else
  assign rot_base = '0;
`endif

  // Selection: scan neurons in priority order starting at rot_base, accepting
  // fresh spikes until the free winner slots are used up.
  logic [N_NEURONS-1:0] sampled;
  logic [N_NEURONS-1:0] accept;
  logic [IW-1:0]        slots;
  logic [IW-1:0]        acc_n;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        first_idx;
  logic                 found;

  always_comb begin
    sampled   = spike_in & ~seen_q;
    slots     = K_L - count_q;
    accept    = '0;
    acc_n     = '0;
    idx       = '0;
    first_idx = '1;
    found     = 1'b0;
    for (int j = 0; j < N_NEURONS; j++) begin
      idx = rot_base + IW'(j);
      if (idx >= N_L) idx = idx - N_L;   // wrap the rotated index
      if (sampled[idx[IX-1:0]] && (acc_n < slots)) begin
        accept[idx[IX-1:0]] = 1'b1;
        acc_n = acc_n + IW'(1);
        if (!found) begin
          found     = 1'b1;
          first_idx = idx;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    time_d         = time_q;
    seen_d         = seen_q;
    count_d        = count_q;
    work_mask_d    = work_mask_q;
    work_fw_d      = work_fw_q;
    work_ft_d      = work_ft_q;
    spike_out_d    = '0;
    win_mask_d     = win_mask_q;
    win_count_d    = win_count_q;
    first_winner_d = first_winner_q;
    first_time_d   = first_time_q;
`ifdef KWTA_TIE_ROTATE_EN
    ptr_d          = ptr_q;
    ptr_next       = '0;
`endif
    if (gamma_start) begin
      // New period from any state; in RUN this is an abort that drops the
      // volley of this cycle and all working state.
      state_d     = S_RUN;
      time_d      = '0;
      seen_d      = '0;
      count_d     = '0;
      work_mask_d = '0;
      work_fw_d   = '1;
      work_ft_d   = T_L;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          seen_d      = seen_q | spike_in;
          count_d     = count_q + acc_n;
          work_mask_d = work_mask_q | accept;
          spike_out_d = accept;
          if (found && (count_q == '0)) begin
            work_fw_d = first_idx;
            work_ft_d = time_q;
          end
          if (time_q == T_LAST) begin
            // Publish on entry to DONE so results are valid with period_done.
            state_d        = S_DONE;
            time_d         = T_L;
            win_mask_d     = work_mask_d;
            win_count_d    = count_d;
            first_winner_d = work_fw_d;
            first_time_d   = work_ft_d;
`ifdef KWTA_TIE_ROTATE_EN
            if (count_d != '0) begin
              ptr_next = work_fw_d + IW'(1);
              ptr_d    = (ptr_next == N_L) ? '0 : ptr_next;
            end
`endif
          end else begin
            time_d = time_q + TW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      time_q         <= T_L;
      seen_q         <= '0;
      count_q        <= '0;
      work_mask_q    <= '0;
      work_fw_q      <= '1;
      work_ft_q      <= T_L;
      spike_out_q    <= '0;
      win_mask_q     <= '0;
      win_count_q    <= '0;
      first_winner_q <= '1;
      first_time_q   <= T_L;
`ifdef KWTA_TIE_ROTATE_EN
      ptr_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      time_q         <= time_d;
      seen_q         <= seen_d;
      count_q        <= count_d;
      work_mask_q    <= work_mask_d;
      work_fw_q      <= work_fw_d;
      work_ft_q      <= work_ft_d;
      spike_out_q    <= spike_out_d;
      win_mask_q     <= win_mask_d;
      win_count_q    <= win_count_d;
      first_winner_q <= first_winner_d;
      first_time_q   <= first_time_d;
`ifdef KWTA_TIE_ROTATE_EN
      ptr_q          <= ptr_d;
`endif
    end
  end

  assign spike_out    = spike_out_q;
  assign time_val     = time_q;
  assign busy         = (state_q == S_RUN);
  assign period_done  = (state_q == S_DONE);
  assign win_mask     = win_mask_q;
  assign win_count    = win_count_q;
  assign first_winner = first_winner_q;
  assign first_time   = first_time_q;

endmodule

// File: tb/tb_kwta_inhibition.sv
module tb_kwta_inhibition;

  localparam int N  = 16;
  localparam int T  = 8;
  localparam int K  = 2;
  localparam int TW = $clog2(T) + 1;
  localparam int IW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gamma_start = 1'b0;
  logic [N-1:0]  spike_in = '0;
  logic [N-1:0]  spike_out;
  logic [TW-1:0] time_val;
  logic          busy;
  logic          period_done;
  logic [N-1:0]  win_mask;
  logic [IW-1:0] win_count;
  logic [IW-1:0] first_winner;
  logic [TW-1:0] first_time;

  always #5 clk = ~clk;

  kwta_inhibition #(.N_NEURONS(N), .T_PERIOD(T), .K_WINNERS(K)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gamma_start  (gamma_start),
    .spike_in     (spike_in),
    .spike_out    (spike_out),
    .time_val     (time_val),
    .busy         (busy),
    .period_done  (period_done),
    .win_mask     (win_mask),
    .win_count    (win_count),
    .first_winner (first_winner),
    .first_time   (first_time)
  );

  typedef struct packed {
    logic [N-1:0]  m;
    logic [IW-1:0] c;
    logic [IW-1:0] fw;
    logic [TW-1:0] ft;
  } res_t;

  res_t         exp_res[$];
  logic [N-1:0] exp_spk[$];
  int           exp_time[$];

  int           checks = 0;
  int           errors = 0;
  int           model_ptr = 0;
  logic [N-1:0] vol [T];
  logic [N-1:0] mspk [T];
  res_t         mres;
  res_t         mon_r;
  logic         mon_en = 1'b0;
  logic         prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: walk the period time by time; at each time collect neurons
  // spiking for the first time, list them in priority order, and hand out the
  // remaining winner slots in that order.
  task automatic model(input int n);
    logic [N-1:0] seen;
    int cnt;
    int q[$];
    seen = '0;
    cnt  = 0;
    mres.m  = '0;
    mres.fw = '1;
    mres.ft = TW'(T);
    for (int t = 0; t < T; t++) mspk[t] = '0;
    for (int t = 0; t < n; t++) begin
      q.delete();
      for (int j = 0; j < N; j++) begin
        int id;
        id = (model_ptr + j) % N;
        if (vol[t][id] && !seen[id]) q.push_back(id);
      end
      seen = seen | vol[t];
      for (int i = 0; i < q.size(); i++) begin
        if (cnt < K) begin
          if (cnt == 0) begin
            mres.fw = IW'(q[i]);
            mres.ft = TW'(t);
          end
          mspk[t][q[i]] = 1'b1;
          cnt++;
        end
      end
      mres.m = mres.m | mspk[t];
    end
    mres.c = IW'(cnt);
  endtask

  task automatic clear_vol();
    for (int t = 0; t < T; t++) vol[t] = '0;
  endtask

  task automatic random_vol();
    bit sparse;
    clear_vol();
    sparse = $urandom_range(0, 1) == 1;
    for (int i = 0; i < N; i++) begin
      int st, len;
      st  = $urandom_range(0, T + 3);
      len = $urandom_range(1, 3);
      if (!sparse || ($urandom_range(0, 3) == 0))
        for (int t = st; t < st + len; t++)
          if (t < T) vol[t][i] = 1'b1;
    end
  endtask

  task automatic reset_value_checks(input string tag);
    check({tag, "_spike_out"}, 32'(spike_out), 32'd0);
    check({tag, "_win_mask"}, 32'(win_mask), 32'd0);
    check({tag, "_win_count"}, 32'(win_count), 32'd0);
    check({tag, "_first_winner"}, 32'(first_winner), 32'((1 << IW) - 1));
    check({tag, "_first_time"}, 32'(first_time), 32'(T));
    check({tag, "_time_val"}, 32'(time_val), 32'(T));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_period_done"}, 32'(period_done), 32'd0);
  endtask

  // One period: gamma_start cycle, then vol[0..] one per cycle. abort_at >= 0
  // stops early so the next call's gamma_start aborts; rst_at >= 0 pulls reset
  // asynchronously in the middle of cycle t == rst_at.
  task automatic run_period(input int abort_at, input int rst_at);
    int n;
    n = (abort_at >= 0) ? abort_at : T;
    model(n);
    for (int t = 0; t < n; t++) begin
      exp_time.push_back(t);
      exp_spk.push_back(mspk[t]);
    end
    if (abort_at >= 0) begin
      exp_time.push_back(abort_at);
      exp_spk.push_back('0);
    end else if (rst_at < 0) begin
      exp_res.push_back(mres);
`ifdef KWTA_TIE_ROTATE_EN
      if (mres.c != 0) model_ptr = (int'(mres.fw) + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    gamma_start = 1'b1;
    spike_in    = N'($urandom);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      gamma_start = 1'b0;
      spike_in    = vol[t];
      if (t == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        reset_value_checks("async_rst");
        exp_res.delete();
        exp_spk.delete();
        exp_time.delete();
        model_ptr = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
      gamma_start = 1'b0;
      spike_in    = N'($urandom);
    end
  endtask

  // Monitor: checks per-cycle outputs against queued expectations and pops a
  // period result whenever period_done is presented.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy) begin
        if (exp_spk.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spk_queue: got empty queue expected an entry at %0t", $time);
        end else begin
          check("spike_out", 32'(spike_out), 32'(exp_spk.pop_front()));
        end
      end else begin
        check("spike_out_quiet", 32'(spike_out), 32'd0);
      end
      if (busy) begin
        if (exp_time.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL time_queue: got busy with empty queue expected idle at %0t", $time);
        end else begin
          check("time_val", 32'(time_val), 32'(exp_time.pop_front()));
        end
      end else begin
        check("time_val_idle", 32'(time_val), 32'(T));
      end
      if (period_done) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL period_done: got unexpected pulse expected none at %0t", $time);
        end else begin
          mon_r = exp_res.pop_front();
          check("win_mask", 32'(win_mask), 32'(mon_r.m));
          check("win_count", 32'(win_count), 32'(mon_r.c));
          check("first_winner", 32'(first_winner), 32'(mon_r.fw));
          check("first_time", 32'(first_time), 32'(mon_r.ft));
          $display("period: mask=%04h count=%0d first=%0d t=%0d", win_mask, win_count,
                   first_winner, first_time);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    bit aborted;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_value_checks("por");
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Simultaneous spikes beyond the free slots, later spikes blocked.
    clear_vol();
    vol[2] = (N'(1) << 9) | (N'(1) << 4) | (N'(1) << 12);
    vol[3] = N'(1) << 5;
    vol[4] = (N'(1) << 2) | (N'(1) << 5);
    run_period(-1, -1);
    // Empty period, back to back.
    clear_vol();
    run_period(-1, -1);
    // One neuron held for the whole period counts once.
    for (int t = 0; t < T; t++) vol[t] = N'(1) << 7;
    run_period(-1, -1);
    idle(3);

    for (int p = 0; p < 40; p++) begin
      random_vol();
      aborted = ($urandom_range(0, 7) == 0);
      run_period(aborted ? int'($urandom_range(0, T - 1)) : -1, -1);
      if (!aborted && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
    end
    idle(2);

    // Abort twice, then reset in the middle of a period with outputs active.
    for (int t = 0; t < T; t++) vol[t] = N'(1) << 7;
    run_period(-1, -1);
    random_vol();
    run_period(5, -1);
    random_vol();
    run_period(3, -1);
    clear_vol();
    vol[3] = N'(1) << 1;
    run_period(-1, 4);
    idle(2);

    for (int p = 0; p < 6; p++) begin
      random_vol();
      run_period(-1, -1);
    end
    idle(4);
    check("res_drain", 32'(exp_res.size()), 32'd0);
    check("spk_drain", 32'(exp_spk.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
